// File: rtl/fetch_queue.sv
// fetch_queue: N-wide instruction fetch feeding a circular queue towards decode.
// Each cycle FETCH_WIDTH consecutive words are read at pc; the leading run of
// nonzero, in-range words is enqueued in program order. A zero or out-of-range
// word marks end of program and stops fetch until flush or reset.
module fetch_queue #(
  parameter int          FETCH_WIDTH = 2,
  parameter int          DEPTH       = 8,
  parameter int          IMEM_BYTES  = 128,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [31:0]                      imem_addr,
  input  logic [32*FETCH_WIDTH-1:0]        imem_rdata,
  output logic                             fetch_en,
  output logic [FETCH_WIDTH-1:0]           out_valid,
  output logic [32*FETCH_WIDTH-1:0]        out_instr,
  output logic [32*FETCH_WIDTH-1:0]        out_pc,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0] deq_count,
  input  logic                             flush,
  input  logic [31:0]                      redirect_pc,
  output logic                             halted,
  output logic [$clog2(DEPTH+1)-1:0]       occupancy,
  output logic [31:0]                      total_instr_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam int CNT_W = $clog2(FETCH_WIDTH+1);

  // Fetch may proceed only while a full fetch group still fits.
  localparam logic [OCC_W-1:0] OCC_FETCH_MAX = OCC_W'(DEPTH - FETCH_WIDTH);
  localparam logic [CNT_W-1:0] FULL_GROUP    = CNT_W'(FETCH_WIDTH);
  localparam logic [32:0]      MEM_LIMIT     = 33'(IMEM_BYTES);
  localparam logic [31:0]      PC_STEP       = 32'(4*FETCH_WIDTH);

  logic [31:0]      pc_q;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [OCC_W-1:0] occ_q;
  logic             halted_q;
  logic [31:0]      total_q;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic [32:0]            slot_end [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] slot_ok;
  logic [CNT_W-1:0]       k;
  logic [OCC_W-1:0]       deq_ext;
  logic [OCC_W-1:0]       eff;
  logic [OCC_W-1:0]       enq_cnt;

  // Per-slot validity: word must be nonzero and lie entirely inside memory.
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_end[i] = {1'b0, pc_q} + 33'(4*i + 3);
      slot_ok[i]  = (imem_rdata[32*i +: 32] != 32'h0) && (slot_end[i] < MEM_LIMIT);
    end
  end

  // Length of the leading valid run; scanning downwards leaves the first zero slot.
  always_comb begin
    k = FULL_GROUP;
    for (int i = FETCH_WIDTH-1; i >= 0; i--) begin
      if (!slot_ok[i]) k = CNT_W'(i);
    end
  end

  // Fetch strobe, clamped dequeue amount and enqueue amount for this cycle.
  always_comb begin
    fetch_en = !rst && !halted_q && !flush && (occ_q <= OCC_FETCH_MAX);
    deq_ext  = OCC_W'(deq_count);
    eff      = (deq_ext > occ_q) ? occ_q : deq_ext;
    enq_cnt  = fetch_en ? OCC_W'(k) : '0;
  end

  // Control state: pc, queue pointers, occupancy, halt flag and instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      head_q   <= '0;
      tail_q   <= '0;
      occ_q    <= '0;
      halted_q <= 1'b0;
      total_q  <= '0;
    end else if (flush) begin
      pc_q     <= redirect_pc;
      head_q   <= '0;
      tail_q   <= '0;
      occ_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      head_q <= head_q + PTR_W'(eff);
      occ_q  <= occ_q + enq_cnt - eff;
      if (fetch_en) begin
        tail_q  <= tail_q + PTR_W'(k);
        total_q <= total_q + 32'(k);
        if (k < FULL_GROUP) begin
          halted_q <= 1'b1;
        end else begin
          pc_q <= pc_q + PC_STEP;
        end
      end
    end
  end

  // Queue storage: write the accepted slots at tail with their addresses.
  always_ff @(posedge clk) begin
    if (fetch_en) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (CNT_W'(i) < k) begin
          instr_mem[tail_q + PTR_W'(i)] <= imem_rdata[32*i +: 32];
          pc_mem[tail_q + PTR_W'(i)]    <= pc_q + 32'(4*i);
        end
      end
    end
  end

  // Present the oldest entries to decode; contents beyond occupancy are don't-care.
  always_comb begin
    out_valid = '0;
    out_instr = '0;
    out_pc    = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      out_valid[i]         = occ_q > OCC_W'(i);
      out_instr[32*i +: 32] = instr_mem[head_q + PTR_W'(i)];
      out_pc[32*i +: 32]    = pc_mem[head_q + PTR_W'(i)];
    end
  end

  assign imem_addr         = pc_q;
  assign halted            = halted_q;
  assign occupancy         = occ_q;
  assign total_instr_count = total_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios with a scoreboard queue of expected entries.
module tb_fetch_queue;

  localparam int FW         = 2;
  localparam int DEPTH      = 8;
  localparam int IMEM_BYTES = 128;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [31:0]     imem_addr;
  logic [32*FW-1:0] imem_rdata = '0;
  logic            fetch_en;
  logic [FW-1:0]   out_valid;
  logic [32*FW-1:0] out_instr;
  logic [32*FW-1:0] out_pc;
  logic [1:0]      deq_count = '0;
  logic            flush = 1'b0;
  logic [31:0]     redirect_pc = '0;
  logic            halted;
  logic [3:0]      occupancy;
  logic [31:0]     total_instr_count;

  fetch_queue #(
    .FETCH_WIDTH(FW), .DEPTH(DEPTH), .IMEM_BYTES(IMEM_BYTES), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .fetch_en(fetch_en), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .deq_count(deq_count), .flush(flush),
    .redirect_pc(redirect_pc), .halted(halted), .occupancy(occupancy),
    .total_instr_count(total_instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t      sb[$];
  logic [31:0] mem_words [32];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_total;
  logic        exp_halted;
  logic [31:0] t_before;

  // Beyond the memory bound the bus returns nonzero garbage the DUT must ignore.
  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (({1'b0, a} + 33'd3) < 33'(IMEM_BYTES)) return mem_words[a[6:2]];
    return 32'hBAD0_0000 | a;
  endfunction

  function automatic bit slot_valid(input logic [31:0] a);
    return (({1'b0, a} + 33'd3) < 33'(IMEM_BYTES)) && (mem_words[a[6:2]] != 32'h0);
  endfunction

  task automatic drive_rdata();
    for (int i = 0; i < FW; i++) imem_rdata[32*i +: 32] = rd_word(imem_addr + 32'(4*i));
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 32; i++) mem_words[i] = 32'hA000_0000 | 32'(i + 1);
  endtask

  task automatic do_reset(input bit fl);
    rst = 1'b1; flush = fl; redirect_pc = 32'h40; deq_count = 2'd2;
    drive_rdata();
    @(negedge clk);
    check("rst_fetch_en", 64'(fetch_en), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    sb.delete(); exp_pc = 32'h0; exp_halted = 1'b0; exp_total = 32'h0;
    drive_rdata();
    check("rst_occupancy", 64'(occupancy), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_imem_addr", 64'(imem_addr), 64'(0));
    check("rst_halted", 64'(halted), 64'(0));
    check("rst_total", 64'(total_instr_count), 64'(0));
  endtask

  // One clock: compare DUT against the model before the edge, then advance the model.
  task automatic step(input int deq, input bit fl, input logic [31:0] rpc);
    int     eff;
    int     k;
    bit     fe;
    entry_t e;
    deq_count = 2'(deq); flush = fl; redirect_pc = rpc;
    drive_rdata();
    @(negedge clk);
    fe = !exp_halted && !fl && ((DEPTH - sb.size()) >= FW);
    check("fetch_en", 64'(fetch_en), 64'(fe));
    check("imem_addr", 64'(imem_addr), 64'(exp_pc));
    check("occupancy", 64'(occupancy), 64'(sb.size()));
    check("halted", 64'(halted), 64'(exp_halted));
    check("total", 64'(total_instr_count), 64'(exp_total));
    for (int i = 0; i < FW; i++) begin
      check($sformatf("out_valid%0d", i), 64'(out_valid[i]), 64'(sb.size() > i));
      if (sb.size() > i) begin
        check($sformatf("out_pc%0d", i), 64'(out_pc[32*i +: 32]), 64'(sb[i].pc));
        check($sformatf("out_instr%0d", i), 64'(out_instr[32*i +: 32]), 64'(sb[i].instr));
      end
    end
    if (fl) begin
      sb.delete(); exp_pc = rpc; exp_halted = 1'b0;
    end else begin
      eff = (deq < sb.size()) ? deq : sb.size();
      repeat (eff) void'(sb.pop_front());
      if (fe) begin
        k = FW;
        for (int i = FW-1; i >= 0; i--) if (!slot_valid(exp_pc + 32'(4*i))) k = i;
        for (int i = 0; i < k; i++) begin
          e.pc = exp_pc + 32'(4*i);
          e.instr = rd_word(e.pc);
          sb.push_back(e);
        end
        exp_total = exp_total + 32'(k);
        if (k < FW) exp_halted = 1'b1;
        else exp_pc = exp_pc + 32'(4*FW);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // Scenario 1: six instructions then a zero word, decode takes two per cycle.
    fill_mem();
    mem_words[6] = 32'h0;
    do_reset(1'b0);
    repeat (6) step(2, 1'b0, 32'h0);
    check("t1_total", 64'(total_instr_count), 64'(6));
    check("t1_halted", 64'(halted), 64'(1));
    check("t1_pc", 64'(imem_addr), 64'(24));

    // Scenario 2: no dequeue until full, then trickle one per cycle.
    fill_mem();
    do_reset(1'b0);
    repeat (4) step(0, 1'b0, 32'h0);
    check("t2_occupancy", 64'(occupancy), 64'(8));
    check("t2_pc", 64'(imem_addr), 64'(32));
    check("t2_fetch_stall", 64'(fetch_en), 64'(0));
    repeat (5) step(1, 1'b0, 32'h0);

    // Scenario 3: fill, then alternate dequeue/enqueue so pointers wrap, then drain.
    do_reset(1'b0);
    repeat (4) step(0, 1'b0, 32'h0);
    for (int i = 0; i < 20; i++) step((i % 2 == 0) ? 2 : 0, 1'b0, 32'h0);
    repeat (10) step(2, 1'b0, 32'h0);
    check("t3_drained", 64'(occupancy), 64'(0));
    check("t3_total", 64'(total_instr_count), 64'(32));

    // Scenario 4: partial group halts, flush redirects to 0x40.
    mem_words[11] = 32'h0;
    step(0, 1'b1, 32'd40);
    t_before = exp_total;
    repeat (2) step(0, 1'b0, 32'h0);
    check("t4_halted", 64'(halted), 64'(1));
    check("t4_total", 64'(total_instr_count), 64'(t_before + 32'd1));
    step(0, 1'b1, 32'h40);
    check("t4_flush_occ", 64'(occupancy), 64'(0));
    check("t4_flush_halted", 64'(halted), 64'(0));
    check("t4_flush_pc", 64'(imem_addr), 64'(32'h40));
    repeat (3) step(2, 1'b0, 32'h0);

    // Scenario 5: last word of memory; the next slot is out of range.
    step(0, 1'b1, 32'd124);
    t_before = exp_total;
    step(0, 1'b0, 32'h0);
    check("t5_halted", 64'(halted), 64'(1));
    check("t5_occ", 64'(occupancy), 64'(1));
    check("t5_total", 64'(total_instr_count), 64'(t_before + 32'd1));
    step(1, 1'b0, 32'h0);

    // Scenario 6: reset together with flush while five entries are queued.
    fill_mem();
    mem_words[5] = 32'h0;
    do_reset(1'b0);
    repeat (3) step(0, 1'b0, 32'h0);
    check("t6_occ5", 64'(occupancy), 64'(5));
    do_reset(1'b1);
    mem_words[0] = 32'h0;
    repeat (2) step(2, 1'b0, 32'h0);
    check("t6_empty_occ", 64'(occupancy), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
